pwm_capture: RTL and testbench

//  Receive-side counterpart to the team's pwm generator.

---
 rtl/pwm_capture_pkg.sv | 25 ++
 rtl/pwm_capture_sync_edge.sv | 32 +++
 rtl/pwm_capture.sv | 157 +++++++++++++++
 tb/tb_pwm_capture.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/pwm_capture_pkg.sv
// Shared types and helpers for the PWM capture block.
package pwm_capture_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    localparam int DEF_W       = 10;
    localparam int DEF_TIMEOUT = 1023;

    // Increment when enabled, sticking at max_val instead of wrapping.
    function automatic int unsigned sat_inc(input int unsigned cnt,
                                            input int unsigned max_val,
                                            input logic        en);
        int unsigned res;
        res = cnt;
        if (en && (cnt < max_val)) begin
            res = cnt + 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/pwm_capture_sync_edge.sv
// Brings the asynchronous PWM pin into the clk domain and flags its edges.
module pwm_capture_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic sync_p0;
    logic sync_p1;

    // Two-flop synchronizer, then level and edge pulses registered together
    // so level, rise and fall stay aligned for the FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            level   <= 1'b0;
            rise    <= 1'b0;
            fall    <= 1'b0;
        end else begin
            sync_p0 <= pin;
            sync_p1 <= sync_p0;
            level   <= sync_p1;
            rise    <= sync_p1 & ~level;
            fall    <= ~sync_p1 & level;
        end
    end

endmodule

// File: rtl/pwm_capture.sv
// Measures high time and period of a PWM input in tick units, with a
// stuck-input timeout; results published with a one-cycle valid strobe.
module pwm_capture
    import pwm_capture_pkg::*;
#(
    parameter int W       = DEF_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         tick,
    input  logic         pwm_in,
    output logic [W-1:0] duty,
    output logic [W-1:0] period,
    output logic         valid,
    output logic         stuck
);

    localparam logic [W-1:0] CNT_MAX = '1;
    localparam logic [W-1:0] TO_LAST = W'(TIMEOUT - 1);

    logic level;
    logic rise;
    logic fall;

    state_t state;
    state_t state_d;

    logic [W-1:0] hi_cnt;
    logic [W-1:0] per_cnt;
    logic [W-1:0] to_cnt;
    logic [W-1:0] hi_cnt_d;
    logic [W-1:0] per_cnt_d;
    logic [W-1:0] to_cnt_d;
    logic [W-1:0] hi_inc;
    logic [W-1:0] per_inc;
    logic [W-1:0] to_inc;
    logic [W-1:0] tick_w;
    logic [W-1:0] duty_d;
    logic [W-1:0] period_d;
    logic         stuck_d;
    logic         valid_d;
    logic         timeout_hit;

    pwm_capture_sync_edge u_sync_edge (
        .clk   (clk),
        .rst   (rst),
        .pin   (pwm_in),
        .level (level),
        .rise  (rise),
        .fall  (fall)
    );

    assign hi_inc  = W'(sat_inc(32'(hi_cnt),  32'(CNT_MAX), tick));
    assign per_inc = W'(sat_inc(32'(per_cnt), 32'(CNT_MAX), tick));
    assign to_inc  = W'(sat_inc(32'(to_cnt),  32'(CNT_MAX), tick));
    assign tick_w  = {{(W-1){1'b0}}, tick};

    // Edges clear to_cnt, so an edge always pre-empts a timeout in the same clk.
    assign timeout_hit = tick && (to_cnt == TO_LAST) && !rise && !fall;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        if (rise) begin
            state_d = HIGH;
        end else if (fall) begin
            if (state == HIGH) begin
                state_d = LOW;
            end
        end else if (timeout_hit) begin
            state_d = IDLE;
        end
    end

    // A tick coincident with an edge is counted into the phase that edge starts.
    always_comb begin
        hi_cnt_d  = hi_cnt;
        per_cnt_d = per_cnt;
        to_cnt_d  = to_inc;
        duty_d    = duty;
        period_d  = period;
        stuck_d   = stuck;
        valid_d   = 1'b0;

        if (rise || fall) begin
            to_cnt_d = '0;
        end else if (timeout_hit) begin
            to_cnt_d = '0;
            duty_d   = level ? CNT_MAX : '0;
            period_d = '0;
            stuck_d  = 1'b1;
            valid_d  = 1'b1;
        end

        case (state)
            IDLE: begin
                if (rise) begin
                    hi_cnt_d  = tick_w;
                    per_cnt_d = tick_w;
                end
            end
            HIGH: begin
                if (rise) begin
                    hi_cnt_d  = tick_w;
                    per_cnt_d = tick_w;
                end else if (fall) begin
                    per_cnt_d = per_inc;
                end else begin
                    hi_cnt_d  = hi_inc;
                    per_cnt_d = per_inc;
                end
            end
            LOW: begin
                if (rise) begin
                    duty_d    = hi_cnt;
                    period_d  = per_cnt;
                    stuck_d   = 1'b0;
                    valid_d   = 1'b1;
                    hi_cnt_d  = tick_w;
                    per_cnt_d = tick_w;
                end else begin
                    per_cnt_d = per_inc;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hi_cnt  <= '0;
            per_cnt <= '0;
            to_cnt  <= '0;
            duty    <= '0;
            period  <= '0;
            stuck   <= 1'b0;
            valid   <= 1'b0;
        end else begin
            hi_cnt  <= hi_cnt_d;
            per_cnt <= per_cnt_d;
            to_cnt  <= to_cnt_d;
            duty    <= duty_d;
            period  <= period_d;
            stuck   <= stuck_d;
            valid   <= valid_d;
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture with a scoreboard of expected publishes.
module tb_pwm_capture;

    localparam int W       = 10;
    localparam int TIMEOUT = 1023;
    localparam int MAXV    = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         tick;
    logic         pwm_in;
    logic [W-1:0] duty;
    logic [W-1:0] period;
    logic         valid;
    logic         stuck;

    always #5 clk = ~clk;

    pwm_capture #(.W(W), .TIMEOUT(TIMEOUT)) dut (
        .clk    (clk),
        .rst    (rst),
        .tick   (tick),
        .pwm_in (pwm_in),
        .duty   (duty),
        .period (period),
        .valid  (valid),
        .stuck  (stuck)
    );

    typedef struct {
        int   duty;
        int   period;
        logic stuck;
        int   due;
    } exp_t;

    exp_t exp_q[$];

    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc_n = 0;
    int   hold_duty;
    int   hold_period;
    logic hold_stuck;
    logic prev_lvl;
    logic armed;
    int   to_m;
    int   hi_last;
    int   lo_last;

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
        n_cmp++;
        assert (obs === req) else begin
            n_err++;
            $error("FAIL %s @cyc %0d: observed %0d, expected %0d", tag, cyc_n, obs, req);
        end
    endtask

    task automatic push_exp(input int d, input int p, input logic s);
        exp_t e;
        e.duty   = d;
        e.period = p;
        e.stuck  = s;
        e.due    = cyc_n;
        exp_q.push_back(e);
    endtask

    task automatic sb_check();
        exp_t e;
        if (exp_q.size() != 0 && exp_q[0].due == cyc_n) begin
            e = exp_q.pop_front();
            check("valid", 32'(valid), 32'd1);
            check("duty", 32'(duty), 32'(e.duty));
            check("period", 32'(period), 32'(e.period));
            check("stuck", 32'(stuck), 32'(e.stuck));
            hold_duty   = e.duty;
            hold_period = e.period;
            hold_stuck  = e.stuck;
        end else begin
            check("no_spurious_valid", 32'(valid), 32'd0);
            if (cyc_n % 64 == 0) begin
                check("hold_duty", 32'(duty), 32'(hold_duty));
                check("hold_period", 32'(period), 32'(hold_period));
                check("hold_stuck", 32'(stuck), 32'(hold_stuck));
            end
        end
    endtask

    task automatic clk_cycle(input logic t, input logic p);
        tick   = t;
        pwm_in = p;
        @(negedge clk);
        sb_check();
        cyc_n++;
    endtask

    // One flat input phase of n tick slots (4 clk each), tick at offset toff.
    // The pin edge is seen by the capture logic 3 clk after it is driven.
    task automatic phase(input logic lvl, input int n, input int toff);
        logic edge_v;
        logic t_v;
        edge_v = (lvl != prev_lvl);
        for (int c = 0; c < 4 * n; c++) begin
            t_v = ((c % 4) == toff);
            if (edge_v && c == 3) begin
                to_m = 0;
                if (lvl) begin
                    if (armed) begin
                        push_exp(imin(hi_last, MAXV), imin(hi_last + lo_last, MAXV), 1'b0);
                    end
                    armed = 1'b1;
                end
            end else if (t_v) begin
                to_m++;
                if (to_m == TIMEOUT) begin
                    push_exp(lvl ? MAXV : 0, 0, 1'b1);
                    to_m  = 0;
                    armed = 1'b0;
                end
            end
            clk_cycle(t_v, lvl);
        end
        prev_lvl = lvl;
        if (lvl) hi_last = n;
        else     lo_last = n;
    endtask

    task automatic do_reset();
        check("drained", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        hold_duty   = 0;
        hold_period = 0;
        hold_stuck  = 1'b0;
        prev_lvl    = 1'b0;
        armed       = 1'b0;
        to_m        = 0;
        rst         = 1'b1;
        clk_cycle(1'b0, pwm_in);
        check("rst_duty", 32'(duty), 32'd0);
        check("rst_period", 32'(period), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_stuck", 32'(stuck), 32'd0);
        clk_cycle(1'b0, pwm_in);
        rst = 1'b0;
    endtask

    initial begin
        rst    = 1'b1;
        tick   = 1'b0;
        pwm_in = 1'b0;
        @(negedge clk);
        do_reset();

        // Generator at duty 300 / 1000, then switch to 700 at a period boundary
        for (int p = 0; p < 3; p++) begin
            phase(1'b1, 300, 0);
            phase(1'b0, 700, 0);
        end
        for (int p = 0; p < 3; p++) begin
            phase(1'b1, 700, 0);
            phase(1'b0, 300, 0);
        end

        // Input stuck low from reset: repeated timeouts
        do_reset();
        phase(1'b0, 2100, 0);

        // Stuck high after one rise, then recovery to a normal report
        do_reset();
        phase(1'b0, 2, 0);
        phase(1'b1, 1100, 0);
        phase(1'b0, 50, 0);
        phase(1'b1, 20, 0);
        phase(1'b0, 30, 0);
        phase(1'b1, 5, 0);

        // Ticks coincident with every edge; then an over-long period that saturates
        do_reset();
        phase(1'b0, 3, 3);
        phase(1'b1, 5, 3);
        phase(1'b0, 7, 3);
        phase(1'b1, 2, 3);
        phase(1'b0, 9, 3);
        phase(1'b1, 600, 3);
        phase(1'b0, 600, 3);
        phase(1'b1, 1, 3);
        phase(1'b0, 4, 3);

        // Reset in the middle of a high phase discards the partial period
        phase(1'b1, 4, 3);
        phase(1'b0, 4, 3);
        phase(1'b1, 3, 3);
        do_reset();
        phase(1'b1, 6, 3);
        phase(1'b0, 4, 3);
        phase(1'b1, 2, 3);
        phase(1'b0, 3, 3);

        check("final_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
